// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART boot loader: sync byte, FSM state encodings
// and the baud-divisor helper.
package loader_pkg;

  localparam logic [7:0] LDR_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } ldr_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-RAM write port: the loader drives it, the RAM consumes it.
interface prog_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);

  logic               we;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] wdata;

  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);

endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte and
// framing-error strobes.
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             valid_n, frame_err_n;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would create races.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
    end
  end

  // NOTE: every signal written below gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          // line back high at mid start bit: it was a glitch
          state_n   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == FULL) begin
          cnt_n     = '0;
          shift_n   = {rx_sync, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == FULL) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rx_sync) valid_n     = 1'b1;
          else         frame_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign data = shift;

endmodule

// File: rtl/prog_loader.sv
// UART boot loader: parses A5|LEN|N x (HI,LO)|CSUM frames, writes the
// instruction RAM and holds the CPU in reset until a frame checks out.
module prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 16,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  prog_loader_if.master imem,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  ldr_state_t         state, state_n;
  logic [7:0]         len_q, len_n, acc_q, acc_n, hi_q, hi_n;
  logic               we_q, we_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [INSTR_W-1:0] wdata_q, wdata_n;
  logic               hold_q, hold_n, done_q, done_n, err_q, err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      len_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= BOOT_HOLD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      len_q   <= len_n;
      acc_q   <= acc_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      hold_q  <= hold_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // NOTE: the hi-byte holding register is pure datapath, always written before
  // it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    hi_q <= hi_n;
  end

  always_comb begin
    state_n = state;
    len_n   = len_q;
    acc_n   = acc_q;
    hi_n    = hi_q;
    we_n    = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    hold_n  = hold_q;
    done_n  = done_q;
    err_n   = err_q;

    // post-increment after each write; wraps after instruction 256
    if (we_q) addr_n = addr_q + 1'b1;

    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (rx_valid && rx_data == LDR_SYNC) begin
          state_n = S_LEN;
          hold_n  = 1'b1;
          done_n  = 1'b0;
          err_n   = 1'b0;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          len_n   = rx_data;
          acc_n   = rx_data;
          addr_n  = '0;
          state_n = S_HI;
        end
      end
      S_HI: begin
        if (rx_valid) begin
          hi_n    = rx_data;
          acc_n   = acc_q ^ rx_data;
          state_n = S_LO;
        end
      end
      S_LO: begin
        if (rx_valid) begin
          acc_n   = acc_q ^ rx_data;
          we_n    = 1'b1;
          wdata_n = INSTR_W'({hi_q, rx_data});
          // addr_q still indexes the instruction just completed
          state_n = (addr_q == ADDR_W'(len_q)) ? S_CSUM : S_HI;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == acc_q) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = S_ERR;
            err_n   = 1'b1;
            hold_n  = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (rx_ferr && (state inside {S_LEN, S_HI, S_LO, S_CSUM})) begin
      state_n = S_ERR;
      err_n   = 1'b1;
      hold_n  = 1'b1;
    end
  end

  assign imem.we    = we_q;
  assign imem.addr  = addr_q;
  assign imem.wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: serialises frames onto uart_rx and checks
// RAM writes, write latency and the hold/done/err flags.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int BIT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic cpu_hold, load_done, load_err;

  prog_loader_if #(.ADDR_W(8), .INSTR_W(16)) imem ();

  prog_loader #(
    .CLK_HZ    (1_000_000),
    .BAUD      (100_000),
    .ADDR_W    (8),
    .INSTR_W   (16),
    .BOOT_HOLD (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .imem      (imem),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_valid_cyc = -100;
  int n_bytes = 0;

  logic [7:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  frame_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write capture plus latency against the receiver's byte strobe.
  always @(negedge clk) begin
    if (imem.we) begin
      wr_addr_q.push_back(imem.addr);
      wr_data_q.push_back(imem.wdata);
      check("we_latency", cyc - last_valid_cyc, 1);
    end
    if (dut.u_rx.valid) begin
      last_valid_cyc = cyc;
      n_bytes++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    uart_rx = stop;
    repeat (BIT) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic build_frame(input bit corrupt, input logic [7:0] bad_csum);
    logic [7:0] acc;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    acc = 8'(exp_q.size() - 1);
    frame_q.push_back(acc);
    foreach (exp_q[i]) begin
      frame_q.push_back(exp_q[i][15:8]);
      frame_q.push_back(exp_q[i][7:0]);
      acc = acc ^ exp_q[i][15:8] ^ exp_q[i][7:0];
    end
    frame_q.push_back(corrupt ? bad_csum : acc);
  endtask

  task automatic verify_writes(input string tag);
    check({tag, "_nwr"}, wr_data_q.size(), exp_q.size());
    if (wr_data_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        check({tag, "_addr"}, wr_addr_q[i], i);
        check({tag, "_data"}, wr_data_q[i], exp_q[i]);
      end
    end
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_flags(input string tag, input logic hold, input logic done, input logic err);
    check({tag, "_hold"}, cpu_hold, hold);
    check({tag, "_done"}, load_done, done);
    check({tag, "_err"}, load_err, err);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    // 1: reset state and idle line
    repeat (5) @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_flags("reset", 1'b1, 1'b0, 1'b0);
    check("reset_we", imem.we, 0);
    check("reset_addr", imem.addr, 0);
    check("reset_wdata", imem.wdata, 0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("idle_nwr", wr_data_q.size(), 0);

    // 2: good two-instruction frame
    exp_q = '{16'h1234, 16'hABCD};
    build_frame(1'b0, 8'h00);
    check("t2_csum", frame_q[6], 8'h41);
    send_frame();
    verify_writes("t2");
    check_flags("t2", 1'b0, 1'b1, 1'b0);

    // 3: bad checksum, then recovery
    build_frame(1'b1, 8'h00);
    send_frame();
    verify_writes("t3bad");
    check_flags("t3bad", 1'b1, 1'b0, 1'b1);
    build_frame(1'b0, 8'h00);
    send_frame();
    verify_writes("t3good");
    check_flags("t3good", 1'b0, 1'b1, 1'b0);

    // 4: junk before sync is ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t4_junk_nwr", wr_data_q.size(), 0);
    check_flags("t4_junk", 1'b0, 1'b1, 1'b0);
    exp_q = '{16'h5AC3};
    build_frame(1'b0, 8'h00);
    send_frame();
    verify_writes("t4");
    check_flags("t4", 1'b0, 1'b1, 1'b0);

    // 5: framing error on HI byte, then idle-line glitch
    base = n_bytes;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h12, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t5_bytes", n_bytes - base, 2);
    check_flags("t5_ferr", 1'b1, 1'b0, 1'b1);
    check("t5_state", dut.state, S_ERR);
    base = n_bytes;
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    uart_rx = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("t5_glitch_bytes", n_bytes - base, 0);
    check("t5_glitch_nwr", wr_data_q.size(), 0);
    check_flags("t5_glitch", 1'b1, 1'b0, 1'b1);

    // 6: full 256-instruction frame
    exp_q.delete();
    for (int a = 0; a < 256; a++) exp_q.push_back(16'(a * 257));
    build_frame(1'b0, 8'h00);
    check("t6_csum", frame_q[frame_q.size() - 1], 8'hFF);
    send_frame();
    verify_writes("t6");
    check_flags("t6", 1'b0, 1'b1, 1'b0);
    check("t6_addr_wrap", imem.addr, 0);

    // reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", dut.state, S_IDLE);
    check_flags("rst", 1'b1, 1'b0, 1'b0);
    check("rst_we", imem.we, 0);
    check("rst_addr", imem.addr, 0);
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_tail_nwr", wr_data_q.size(), 0);
    check_flags("rst_tail", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
